// File: rtl/frame_pkg.sv
// ============================================================================
// frame_pkg : shared frame geometry, FSM state type and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package frame_pkg;

  localparam int DEF_WORD_W  = 32;
  localparam int FRAME_WORDS = 16;
  localparam int COLS        = 4;
  localparam int CNT_W       = 5;

  // Column-0 word indices {0,4,8,12}, packed low index first.
  localparam logic [15:0] COL0_IDX = {4'd12, 4'd8, 4'd4, 4'd0};

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WR_SMALL = 2'd1,
    WR_BIG   = 2'd2,
    DONE     = 2'd3
  } frame_state_t;

  function automatic logic is_col0(input logic [3:0] idx);
    return (idx[1:0] == 2'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_phase_timer.sv
// ============================================================================
// frame_phase_timer : HOLD_CYCLES down-counter, expires on the last hold cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_phase_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expire
);

  localparam logic [3:0] c_RELOAD = 4'(HOLD_CYCLES - 1);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= c_RELOAD;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_expire = (r_count == 4'd0);

endmodule

`default_nettype wire

// File: rtl/frame_loader.sv
// ============================================================================
// frame_loader : assembles a 4x4 word frame and drives the Small/Big write
// sequence. Optional frame_xor output when FRAME_LOADER_XOR_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_loader
  import frame_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_W-1:0]             word_in,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic                          flush,
  output logic [FRAME_WORDS*WORD_W-1:0] frame_out,
  output logic                          write,
  output logic                          Small_or_Big,
  output logic                          frame_done,
`ifdef FRAME_LOADER_XOR_EN
  output logic [WORD_W-1:0]             frame_xor,
`endif
  output logic [CNT_W-1:0]              word_cnt
);

  frame_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_ready, r_write, r_sob, r_done, w_sob_nxt;
  logic [WORD_W-1:0] r_frame [FRAME_WORDS];

  logic w_accept, w_take, w_small_exp, w_big_exp, w_load_small, w_load_big;

  assign w_accept     = word_valid & r_ready;
  assign w_take       = w_accept & ~flush;
  assign w_load_small = w_take && (r_cnt == 5'd15);
  assign w_load_big   = (r_state == WR_SMALL) && w_small_exp;

  frame_phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_small_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load_small),
    .o_expire (w_small_exp)
  );

  frame_phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_big_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load_big),
    .o_expire (w_big_exp)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      FILL: begin
        if (flush) begin
          w_cnt_nxt = 5'd0;
        end else if (w_accept) begin
          w_cnt_nxt = r_cnt + 5'd1;
          if (r_cnt == 5'd15) w_state_nxt = WR_SMALL;
        end
      end
      WR_SMALL: if (w_small_exp) w_state_nxt = WR_BIG;
      WR_BIG:   if (w_big_exp)   w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = FILL;
        w_cnt_nxt   = 5'd0;
      end
      default: w_state_nxt = FILL;
    endcase

    // Small_or_Big only moves on phase entry; it keeps 1 while idle.
    case (w_state_nxt)
      WR_SMALL: w_sob_nxt = 1'b0;
      WR_BIG:   w_sob_nxt = 1'b1;
      default:  w_sob_nxt = r_sob;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= 5'd0;
      r_ready <= 1'b1;
      r_write <= 1'b0;
      r_sob   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == FILL);
      r_write <= (w_state_nxt == WR_SMALL) || (w_state_nxt == WR_BIG);
      r_sob   <= w_sob_nxt;
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_WORDS; i++) r_frame[i] <= '0;
    end else if (w_take) begin
      r_frame[r_cnt[3:0]] <= word_in;
    end
  end

  for (genvar gi = 0; gi < FRAME_WORDS; gi++) begin : g_flat
    assign frame_out[gi*WORD_W +: WORD_W] = r_frame[gi];
  end

`ifdef FRAME_LOADER_XOR_EN
  logic [WORD_W-1:0] r_xor;

  always_ff @(posedge clk) begin
    if (rst || (r_state == DONE) || ((r_state == FILL) && flush)) begin
      r_xor <= '0;
    end else if (w_take) begin
      r_xor <= r_xor ^ word_in;
    end
  end

  assign frame_xor = r_xor;
`endif

  assign word_ready   = r_ready;
  assign write        = r_write;
  assign Small_or_Big = r_sob;
  assign frame_done   = r_done;
  assign word_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
// ============================================================================
// tb_frame_loader : directed + random stimulus against a timeline model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_loader;

  localparam int W = 32;
  localparam int H = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   word_in = '0;
  logic           word_valid = 1'b0;
  logic           flush = 1'b0;
  logic           word_ready, write, Small_or_Big, frame_done;
  logic [16*W-1:0] frame_out;
  logic [4:0]     word_cnt;
`ifdef FRAME_LOADER_XOR_EN
  logic [W-1:0]   frame_xor;
`endif

  frame_loader #(.WORD_W(W), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .flush        (flush),
    .frame_out    (frame_out),
    .write        (write),
    .Small_or_Big (Small_or_Big),
    .frame_done   (frame_done),
`ifdef FRAME_LOADER_XOR_EN
    .frame_xor    (frame_xor),
`endif
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: el = cycles since the 16th word was taken (0 while filling).
  int         m_el = 0;
  int         m_cnt = 0;
  logic       m_sob = 1'b0;
  logic [W-1:0] m_xor = '0;
  logic [W-1:0] m_frame [16];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    if (r) begin
      m_el = 0; m_cnt = 0; m_sob = 1'b0; m_xor = '0;
      for (int i = 0; i < 16; i++) m_frame[i] = '0;
    end else if (m_el == 0) begin
      if (f) begin
        m_cnt = 0; m_xor = '0;
      end else if (v) begin
        m_frame[m_cnt] = d;
        m_xor = m_xor ^ d;
        m_cnt++;
        if (m_cnt == 16) m_el = 1;
      end
    end else if (m_el == 2*H+1) begin
      m_el = 0; m_cnt = 0; m_xor = '0;
    end else begin
      m_el++;
    end
    if (m_el >= 1 && m_el <= H) m_sob = 1'b0;
    else if (m_el > H && m_el <= 2*H) m_sob = 1'b1;
  endtask

  task automatic check_all();
    logic [16*W-1:0] flat;
    for (int i = 0; i < 16; i++) flat[i*W +: W] = m_frame[i];
    chk("ready", word_ready, (m_el == 0));
    chk("write", write, (m_el >= 1 && m_el <= 2*H));
    chk("sob",   Small_or_Big, m_sob);
    chk("done",  frame_done, (m_el == 2*H+1));
    chk("cnt",   word_cnt, m_cnt[4:0]);
    chk("frame", frame_out, flat);
`ifdef FRAME_LOADER_XOR_EN
    chk("xor",   frame_xor, m_xor);
`endif
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic r);
    word_valid = v; word_in = d; flush = f; rst = r;
    @(posedge clk);
    model_edge(v, d, f, r);
    #1;
    check_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_frame[i] = '0;

    // Reset
    step(1'b1, 32'h1234, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_frame", frame_out, '0);
    chk("rst_ready", word_ready, 1'b1);

    // Back-to-back 0..15, valid held high through the write sequence
    for (int i = 0; i < 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    chk("w5", frame_out[5*W +: W], 32'h5);
    chk("ready_low", word_ready, 1'b0);
    for (int i = 0; i < 2*H; i++) step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("done_at", frame_done, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("ready_back", word_ready, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Partial frame, flush with an 8th word valid, then a full frame
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    chk("cnt7", word_cnt, 5'd7);
    step(1'b1, 32'h77777777, 1'b1, 1'b0);
    chk("flush_cnt", word_cnt, 5'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 32'hA0 + W'(i), 1'b0, 1'b0);
    chk("w0", frame_out[0 +: W], 32'hA0);
    chk("w15", frame_out[15*W +: W], 32'hAF);
    for (int i = 0; i < 2*H+2; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush coinciding with the 16th word
    for (int i = 0; i < 15; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0);
    chk("flush16_write", write, 1'b0);

    // Valid toggling every cycle
    for (int i = 0; i < 32; i++) step((i % 2) == 0, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 2*H+2; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset during WR_BIG
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < H; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("in_big", Small_or_Big, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_big_write", write, 1'b0);
    chk("rst_big_frame", frame_out, '0);
    for (int i = 0; i < 2*H+2; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // One-hot words: XOR of the frame is 0x0000FFFF
    for (int i = 0; i < 16; i++) step(1'b1, 32'h1 << i, 1'b0, 1'b0);
`ifdef FRAME_LOADER_XOR_EN
    chk("xor_ffff", frame_xor, 32'h0000FFFF);
`endif
    for (int i = 0; i < 2*H+2; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FRAME_LOADER_XOR_EN
    chk("xor_clr", frame_xor, 32'h0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3, 0) != 0, $urandom,
           $urandom_range(19, 0) == 0, $urandom_range(149, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the 16-word frame register file.
- Accepts 32-bit words serially over a valid/ready stream and assembles a 4x4 frame (row-major, word i = row i/4, column i%4).
- Drives the two-phase write sequence the register file expects: a Small phase (Small_or_Big=0) commits column 0 (words 0,4,8,12); a Big phase (Small_or_Big=1) commits columns 1-3.
- Presents the full frame on a flattened bus that feeds the register file's frame_N_in inputs.

Parameters:
- WORD_W, 32, width of one frame word; must match the register file.
- HOLD_CYCLES, 1, cycles write stays asserted per phase; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- word_in  input  WORD_W  incoming frame word.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader can accept a word this cycle.
- flush  input  1  discard a partially collected frame.
- frame_out  output  16*WORD_W  word i at bits [i*WORD_W +: WORD_W].
- write  output  1  write strobe to the register file.
- Small_or_Big  output  1  0 = column-0 phase, 1 = columns-1..3 phase.
- frame_done  output  1  one-cycle pulse after the Big phase ends.
- word_cnt  output  5  words collected in the current frame (0..16).

Behaviour:
- Reset (sync, rst=1 at posedge): state=FILL, word_cnt=0, frame_out=0, write=0, Small_or_Big=0, frame_done=0, hold counter=0, word_ready=1 in the following cycle. Reset wins over every other input, including mid-write; any partial frame is lost.
- Handshake: a word transfers when word_valid && word_ready at posedge. word_ready=1 only in FILL. word_in is stored at index word_cnt, then word_cnt increments.
- States (all outputs registered):
  - FILL: accept words. On the accepting edge of the 16th word (word_cnt 15->16), go to WR_SMALL with write=1 and Small_or_Big=0 from the next cycle. Zero-latency transition; no dead cycle.
  - WR_SMALL: write=1, Small_or_Big=0 for exactly HOLD_CYCLES cycles, then WR_BIG.
  - WR_BIG: write=1, Small_or_Big=1 for exactly HOLD_CYCLES cycles, then DONE.
  - DONE: write=0, frame_done=1 for one cycle, word_cnt cleared to 0, then FILL.
- Minimum frame period: 16 + 2*HOLD_CYCLES + 1 cycles.
- frame_out is stable for the whole of WR_SMALL, WR_BIG and DONE. Words already loaded are not cleared between frames; each word is overwritten as the next frame arrives.
- flush:
  - In FILL: word_cnt goes to 0 next cycle. A word presented in the same cycle is discarded; word_ready stays 1.
  - In WR_SMALL, WR_BIG or DONE: ignored.
- Simultaneous flush with the 16th-word handshake: flush wins, word_cnt=0, no write sequence starts.
- word_valid held high with word_ready low: no transfer, no state change.
- Small_or_Big holds its last value (1) while write=0 and returns to 0 on entry to WR_SMALL.

Optional Feature:
- Macro FRAME_LOADER_XOR_EN.
- Defined: adds output frame_xor [WORD_W-1:0], the XOR of all 16 accepted words of the current frame. It is cleared on rst, flush, and DONE exit, accumulated on each handshake, and valid (held stable) from WR_SMALL entry through DONE.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package frame_pkg: WORD_W default, FRAME_WORDS=16, COLS=4, state enum typedef {FILL, WR_SMALL, WR_BIG, DONE}, localparam of column-0 indices {0,4,8,12}.
- Package is reusable by the register file and other frame stages.
- One natural sub-module: frame_phase_timer, a HOLD_CYCLES down-counter with load/expire that the FSM instantiates once per phase.

Test Plan:
- Reset then stream words 0x00000000..0x0000000F back-to-back -> word_ready falls after the 16th handshake; write=1, Small_or_Big=0 for 1 cycle, then Small_or_Big=1 for 1 cycle; frame_done pulses on cycle 19 after the first handshake; frame_out word 5 = 0x00000005.
- HOLD_CYCLES=3, same stream -> write high for 6 consecutive cycles (3 Small, 3 Big); frame_done one cycle after; next frame accepted the cycle after DONE.
- Send 7 words, assert flush with an 8th word valid, then send 16 words 0xA0..0xAF -> word_cnt 7->0; the 8th word is dropped; the frame written has word 0 = 0xA0 and word 15 = 0xAF.
- word_valid toggling 1/0 every cycle over 16 words -> exactly 16 handshakes, write sequence starts only after the last; no duplicated words.
- Assert rst during WR_BIG -> next cycle write=0, Small_or_Big=0, word_cnt=0, frame_out=0, no frame_done pulse.
- FRAME_LOADER_XOR_EN defined, words 0x1,0x2,0x4,...,0x8000 -> frame_xor=0x0000FFFF during WR_SMALL through DONE; 0 after.
